// File: rtl/fp_sqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined FP square-root unit between NUM_REQ requesters.
// Registered issue stage, {id,tag} tagging, per-requester credit counters and a registered response demux.
module fp_sqrt_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned FP_WIDTH   = 32,
   parameter int unsigned TAG_WIDTH  = 4,
   parameter int unsigned RND_WIDTH  = 3,
   parameter int unsigned STAT_WIDTH = 5,
   parameter int unsigned SQRT_LAT   = 1,
   parameter int unsigned MAX_OUTST  = 2,
   parameter int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ-1:0]              req_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   input  logic [NUM_REQ*FP_WIDTH-1:0]     op_a_i,
   input  logic [NUM_REQ*RND_WIDTH-1:0]    rnd_i,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]    tag_i,
   output logic [NUM_REQ-1:0]              resp_valid_o,
   output logic [FP_WIDTH-1:0]             res_o,
   output logic [STAT_WIDTH-1:0]           status_o,
   output logic [TAG_WIDTH-1:0]            tag_o,
   output logic                            sqrt_en_o,
   output logic [FP_WIDTH-1:0]             sqrt_op_a_o,
   output logic [RND_WIDTH-1:0]            sqrt_rnd_o,
   output logic [ID_WIDTH+TAG_WIDTH-1:0]   sqrt_tag_o,
   input  logic                            sqrt_ready_i,
   input  logic                            sqrt_valid_i,
   input  logic [FP_WIDTH-1:0]             sqrt_res_i,
   input  logic [STAT_WIDTH-1:0]           sqrt_status_i,
   input  logic [ID_WIDTH+TAG_WIDTH-1:0]   sqrt_tag_i,
   output logic                            busy_o
);

   localparam int unsigned SQTAG_W = ID_WIDTH + TAG_WIDTH;
   localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);

   // Reject unsupported parameter sets at elaboration
   if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_OUTST < 1 || MAX_OUTST > 7 || SQRT_LAT > 255 ||
       ID_WIDTH != ((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)) begin : g_param_err
      $error("fp_sqrt_arbiter: unsupported parameter set");
   end

   logic [ID_WIDTH-1:0]   r_ptr;
   logic [CNT_W-1:0]      r_outst [NUM_REQ];

   logic                  r_iss_vld;
   logic [FP_WIDTH-1:0]   r_iss_op;
   logic [RND_WIDTH-1:0]  r_iss_rnd;
   logic [SQTAG_W-1:0]    r_iss_tag;

   logic [NUM_REQ-1:0]    r_rsp_vld;
   logic [FP_WIDTH-1:0]   r_rsp_res;
   logic [STAT_WIDTH-1:0] r_rsp_status;
   logic [TAG_WIDTH-1:0]  r_rsp_tag;

   logic [NUM_REQ-1:0]    w_elig;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_gnt_any;
   logic [ID_WIDTH-1:0]   w_gnt_id;
   logic [FP_WIDTH-1:0]   w_sel_op;
   logic [RND_WIDTH-1:0]  w_sel_rnd;
   logic [TAG_WIDTH-1:0]  w_sel_tag;
   logic [ID_WIDTH-1:0]   w_rsp_id;
   logic [NUM_REQ-1:0]    w_rsp_hit;
   logic                  w_any_outst;

   // Round-robin search from r_ptr; a grant issued while in reset would be lost, so none is given
   always_comb begin
      int unsigned v_idx;
      w_elig    = '0;
      w_gnt     = '0;
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      v_idx     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_elig[k] = req_i[k] && (r_outst[k] < CNT_W'(MAX_OUTST)) && sqrt_ready_i && !rst_i;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         v_idx = 32'(r_ptr) + i;
         if (v_idx >= NUM_REQ) begin
            v_idx = v_idx - NUM_REQ;
         end
         if (!w_gnt_any && w_elig[v_idx]) begin
            w_gnt_any    = 1'b1;
            w_gnt[v_idx] = 1'b1;
            w_gnt_id     = ID_WIDTH'(v_idx);
         end
      end
   end

   assign w_sel_op  = op_a_i[32'(w_gnt_id) * FP_WIDTH +: FP_WIDTH];
   assign w_sel_rnd = rnd_i[32'(w_gnt_id) * RND_WIDTH +: RND_WIDTH];
   assign w_sel_tag = tag_i[32'(w_gnt_id) * TAG_WIDTH +: TAG_WIDTH];

   // Responses for unknown ids or requesters with no credit in use are dropped
   assign w_rsp_id = sqrt_tag_i[SQTAG_W-1 -: ID_WIDTH];
   always_comb begin
      w_rsp_hit   = '0;
      w_any_outst = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_rsp_hit[k] = sqrt_valid_i && !rst_i && (w_rsp_id == ID_WIDTH'(k)) &&
                        (r_outst[k] != '0);
         w_any_outst  = w_any_outst || (r_outst[k] != '0);
      end
   end

   // Pointer and issue stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr     <= '0;
         r_iss_vld <= 1'b0;
         r_iss_op  <= '0;
         r_iss_rnd <= '0;
         r_iss_tag <= '0;
      end else begin
         r_iss_vld <= w_gnt_any;
         if (w_gnt_any) begin
            r_ptr     <= (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_iss_op  <= w_sel_op;
            r_iss_rnd <= w_sel_rnd;
            r_iss_tag <= {w_gnt_id, w_sel_tag};
         end
      end
   end

   // Response stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp_vld    <= '0;
         r_rsp_res    <= '0;
         r_rsp_status <= '0;
         r_rsp_tag    <= '0;
      end else begin
         r_rsp_vld <= w_rsp_hit;
         if (|w_rsp_hit) begin
            r_rsp_res    <= sqrt_res_i;
            r_rsp_status <= sqrt_status_i;
            r_rsp_tag    <= sqrt_tag_i[TAG_WIDTH-1:0];
         end
      end
   end

   // Credit counters: grant and accepted response in the same cycle cancel out
   always_ff @(posedge clk_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (rst_i) begin
            r_outst[k] <= '0;
         end else begin
            case ({w_gnt[k], w_rsp_hit[k]})
               2'b10:   r_outst[k] <= r_outst[k] + CNT_W'(1);
               2'b01:   r_outst[k] <= r_outst[k] - CNT_W'(1);
               default: r_outst[k] <= r_outst[k];
            endcase
         end
      end
   end

   assign gnt_o        = w_gnt;
   assign sqrt_en_o    = r_iss_vld;
   assign sqrt_op_a_o  = r_iss_op;
   assign sqrt_rnd_o   = r_iss_rnd;
   assign sqrt_tag_o   = r_iss_tag;
   assign resp_valid_o = r_rsp_vld;
   assign res_o        = r_rsp_res;
   assign status_o     = r_rsp_status;
   assign tag_o        = r_rsp_tag;
   assign busy_o       = w_any_outst || r_iss_vld || (|r_rsp_vld);

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter; the bench also plays a 1-cycle-latency sqrt unit.
module tb_fp_sqrt_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned FW = 32;
   localparam int unsigned TW = 4;
   localparam int unsigned RW = 3;
   localparam int unsigned SW = 5;
   localparam int unsigned IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [NR-1:0]        req;
   logic [NR-1:0]        gnt;
   logic [NR*FW-1:0]     op_a;
   logic [NR*RW-1:0]     rnd_in;
   logic [NR*TW-1:0]     tag_in;
   logic [NR-1:0]        resp_valid;
   logic [FW-1:0]        res;
   logic [SW-1:0]        status;
   logic [TW-1:0]        tag_out;
   logic                 sq_en;
   logic [FW-1:0]        sq_op;
   logic [RW-1:0]        sq_rnd;
   logic [IW+TW-1:0]     sq_tag;
   logic                 ready;
   logic                 sq_valid;
   logic [FW-1:0]        sq_res;
   logic [SW-1:0]        sq_status;
   logic [IW+TW-1:0]     sq_tag_ret;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   // Sqrt unit model: exact results for a few perfect squares, garbage plus inexact flag otherwise
   function automatic logic [SW+FW-1:0] sqrt_ref(input logic [FW-1:0] a);
      case (a)
         32'h3F80_0000: return {5'h00, 32'h3F80_0000};
         32'h4080_0000: return {5'h00, 32'h4000_0000};
         32'h4110_0000: return {5'h00, 32'h4040_0000};
         32'h4180_0000: return {5'h00, 32'h4080_0000};
         default:       return {5'h01, ~a};
      endcase
   endfunction

   logic             u_vld;
   logic [FW-1:0]    u_res;
   logic [SW-1:0]    u_st;
   logic [IW+TW-1:0] u_tag;
   logic             inj;
   logic [FW-1:0]    inj_res;
   logic [IW+TW-1:0] inj_tag;

   always @(posedge clk) begin
      u_vld         <= rst ? 1'b0 : sq_en;
      {u_st, u_res} <= sqrt_ref(sq_op);
      u_tag         <= sq_tag;
   end

   assign sq_valid   = inj ? 1'b1    : u_vld;
   assign sq_res     = inj ? inj_res : u_res;
   assign sq_status  = inj ? 5'h1f   : u_st;
   assign sq_tag_ret = inj ? inj_tag : u_tag;

   fp_sqrt_arbiter dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .gnt_o         (gnt),
      .op_a_i        (op_a),
      .rnd_i         (rnd_in),
      .tag_i         (tag_in),
      .resp_valid_o  (resp_valid),
      .res_o         (res),
      .status_o      (status),
      .tag_o         (tag_out),
      .sqrt_en_o     (sq_en),
      .sqrt_op_a_o   (sq_op),
      .sqrt_rnd_o    (sq_rnd),
      .sqrt_tag_o    (sq_tag),
      .sqrt_ready_i  (ready),
      .sqrt_valid_i  (sq_valid),
      .sqrt_res_i    (sq_res),
      .sqrt_status_i (sq_status),
      .sqrt_tag_i    (sq_tag_ret),
      .busy_o        (busy)
   );

   task automatic set_req(input int k, input logic [FW-1:0] op, input logic [RW-1:0] rm,
                          input logic [TW-1:0] tg);
      op_a[k*FW +: FW]     = op;
      rnd_in[k*RW +: RW]   = rm;
      tag_in[k*TW +: TW]   = tg;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h exp 0", res); end
      checks++; if (status !== 5'h0 || tag_out !== 4'h0) begin errors++; $display("FAIL reset_status_tag got %h/%h exp 0/0", status, tag_out); end
      checks++; if (sq_en !== 1'b0 || sq_op !== 32'h0 || sq_rnd !== 3'h0 || sq_tag !== 6'h0) begin
         errors++; $display("FAIL reset_issue got en=%b op=%h rnd=%h tag=%h exp all 0", sq_en, sq_op, sq_rnd, sq_tag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_single_op();
      do_reset();
      set_req(0, 32'h4080_0000, 3'd2, 4'd5);
      @(negedge clk); req = 4'b0001; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
      @(negedge clk); req = 4'b0000; #1;
      checks++; if (sq_en !== 1'b1 || sq_op !== 32'h4080_0000 || sq_rnd !== 3'd2 || sq_tag !== 6'h05) begin
         errors++; $display("FAIL single_issue got en=%b op=%h rnd=%0d tag=%h exp 1/40800000/2/05", sq_en, sq_op, sq_rnd, sq_tag); end
      @(negedge clk); #1;
      checks++; if (sq_en !== 1'b0 || resp_valid !== 4'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_mid got en=%b rv=%b busy=%b exp 0/0000/1", sq_en, resp_valid, busy); end
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0001 || res !== 32'h4000_0000 || tag_out !== 4'd5 || status !== 5'h0) begin
         errors++; $display("FAIL single_resp got rv=%b res=%h tag=%0d st=%h exp 0001/40000000/5/00", resp_valid, res, tag_out, status); end
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0 || res !== 32'h4000_0000 || busy !== 1'b0) begin
         errors++; $display("FAIL single_after got rv=%b res=%h busy=%b exp 0000/40000000/0", resp_valid, res, busy); end
   endtask

   task automatic test_round_robin();
      logic [FW-1:0] exp_res [NR];
      logic [NR-1:0] exp_g;
      int j;
      exp_res[0] = 32'h3F80_0000; exp_res[1] = 32'h4000_0000;
      exp_res[2] = 32'h4040_0000; exp_res[3] = 32'h4080_0000;
      do_reset();
      set_req(0, 32'h3F80_0000, 3'd0, 4'd8);
      set_req(1, 32'h4080_0000, 3'd1, 4'd9);
      set_req(2, 32'h4110_0000, 3'd2, 4'd10);
      set_req(3, 32'h4180_0000, 3'd3, 4'd11);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         req = (i < 8) ? 4'hF : 4'h0;
         #1;
         exp_g = (i < 8) ? 4'(1 << (i % 4)) : 4'b0;
         checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt cycle %0d got %b exp %b", i, gnt, exp_g); end
         if (i >= 3) begin
            j = (i - 3) % 4;
            checks++; if (resp_valid !== 4'(1 << j) || tag_out !== 4'(j + 8) || res !== exp_res[j]) begin
               errors++; $display("FAIL rr_resp cycle %0d got rv=%b tag=%0d res=%h exp %b/%0d/%h",
                                  i, resp_valid, tag_out, res, 4'(1 << j), j + 8, exp_res[j]); end
         end
      end
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rr_drain got rv=%b busy=%b exp 0000/0", resp_valid, busy); end
   endtask

   task automatic test_credit_limit();
      logic [6:0] pat;
      pat = 7'b1011011;
      do_reset();
      set_req(0, 32'h4110_0000, 3'd1, 4'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); req = 4'b0001; #1;
         checks++; if (gnt !== {3'b0, pat[i]}) begin
            errors++; $display("FAIL credit_gnt cycle %0d got %b exp %b", i, gnt, {3'b0, pat[i]}); end
      end
      @(negedge clk); req = 4'b0000;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL credit_drain_busy got %b exp 0", busy); end
   endtask

   task automatic test_stall();
      do_reset();
      set_req(0, 32'h4080_0000, 3'd0, 4'd3);
      set_req(1, 32'h4180_0000, 3'd1, 4'd7);
      set_req(2, 32'h3F80_0000, 3'd2, 4'd6);
      ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); req = 4'b0110; #1;
         checks++; if (gnt !== 4'b0 || sq_en !== 1'b0) begin
            errors++; $display("FAIL stall_gnt cycle %0d got gnt=%b en=%b exp 0000/0", i, gnt, sq_en); end
      end
      @(negedge clk); ready = 1'b1; #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_release got %b exp 0010", gnt); end
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_next got %b exp 0100", gnt); end
      @(negedge clk); req = 4'b0011; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ptr_wrap got %b exp 0001", gnt); end
      @(negedge clk); req = 4'b0000;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || res !== 32'h4000_0000 || tag_out !== 4'd3) begin
         errors++; $display("FAIL stall_drain got busy=%b res=%h tag=%0d exp 0/40000000/3", busy, res, tag_out); end
   endtask

   task automatic test_drop();
      @(negedge clk);
      inj = 1'b1; inj_res = 32'hDEAD_BEEF; inj_tag = {2'd2, 4'd9};
      @(negedge clk);
      inj = 1'b0;
      #1;
      checks++; if (resp_valid !== 4'b0 || res !== 32'h4000_0000 || tag_out !== 4'd3 || busy !== 1'b0) begin
         errors++; $display("FAIL drop_resp got rv=%b res=%h tag=%0d busy=%b exp 0000/40000000/3/0",
                            resp_valid, res, tag_out, busy); end
   endtask

   task automatic test_reset_mid_flight();
      do_reset();
      set_req(0, 32'h4080_0000, 3'd1, 4'd1);
      set_req(1, 32'h4110_0000, 3'd2, 4'd2);
      set_req(2, 32'h4180_0000, 3'd3, 4'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); req = 4'b0111; #1;
         checks++; if (gnt !== 4'(1 << i)) begin errors++; $display("FAIL mid_gnt cycle %0d got %b exp %b", i, gnt, 4'(1 << i)); end
      end
      @(negedge clk); req = 4'b0000; rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (sq_en !== 1'b0 || sq_op !== 32'h0 || sq_tag !== 6'h0 || resp_valid !== 4'b0 ||
                    res !== 32'h0 || tag_out !== 4'h0 || status !== 5'h0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs got en=%b op=%h stag=%h rv=%b res=%h tag=%h st=%h busy=%b exp all 0",
                            sq_en, sq_op, sq_tag, resp_valid, res, tag_out, status, busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_stale cycle %0d got rv=%b busy=%b exp 0000/0", i, resp_valid, busy); end
      end
      @(negedge clk); req = 4'hF; #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", gnt); end
      @(negedge clk); req = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req = '0; ready = 1'b1; inj = 1'b0;
      inj_res = '0; inj_tag = '0; op_a = '0; rnd_in = '0; tag_in = '0;
      test_reset();
      test_single_op();
      test_round_robin();
      test_credit_limit();
      test_stall();
      test_drop();
      test_reset_mid_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
